ifetch_buf: RTL

IFETCH_BUF -- requirements
Module: ifetch_buf

---
 rtl/ifetch_buf.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ifetch_buf.sv
// ---------------------------------------------------------------------------
// ifetch_buf -- instruction fetch front end with a small in-order queue.
//
// A word-aligned fetch PC addresses a synchronous instruction ROM. At most
// one ROM request is in flight. Each returned word is pushed into a
// DEPTH-entry queue together with its byte address. The consumer pops the
// head with a valid/ready handshake. A redirect pulse flushes everything and
// restarts fetch at a new address.
//
// Ports
//   clock        rising-edge clock, shared with the ROM
//   rst_n        asynchronous active-low reset
//   fetch_en     allow new ROM requests
//   redirect     one-cycle flush/restart pulse
//   redirect_pc  restart byte address (bits [1:0] dropped)
//   rom_addr     ROM word address = pc[13:2]
//   rom_q        ROM data, one cycle after rom_addr
//   inst_valid   queue head valid
//   inst_ready   consumer takes the head this cycle
//   inst_data    head instruction (0 when not valid)
//   inst_pc      head byte address (0 when not valid)
// ---------------------------------------------------------------------------

// One queue slot: a plain enabled register.
module ifetch_buf_entry (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        we,
    input  logic [63:0] d,
    output logic [63:0] q
);
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (we)
            q <= d;
    end
endmodule

module ifetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_q,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);
    localparam logic [31:0] PC_RST  = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } qent_t;

    logic [31:0]   pc;
    logic [31:0]   pend_pc;
    logic          pend;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [CW:0]   occ;
    logic          issue;
    logic          push;
    logic          pop;
    qent_t         wr_ent;
    qent_t         head;
    logic [DEPTH-1:0][63:0] ent_q;

    assign rom_addr = pc[13:2];

    // Credit counts the in-flight word as occupied so a returning word
    // always finds a free slot; same-cycle pops are deliberately ignored.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, pend};
    assign issue = fetch_en && !redirect && (occ < DEPTH_V);
    assign push  = pend && !redirect;
    assign pop   = inst_valid && inst_ready && !redirect;

    assign wr_ent = '{data: rom_q, pc: pend_pc};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            ifetch_buf_entry u_ent (
                .clock (clock),
                .rst_n (rst_n),
                .we    (push && (wr_ptr == PW'(gi))),
                .d     (wr_ent),
                .q     (ent_q[gi])
            );
        end
    endgenerate

    assign head       = ent_q[rd_ptr];
    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? head.data : 32'h0;
    assign inst_pc    = inst_valid ? head.pc   : 32'h0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_RST;
            pend_pc <= '0;
            pend    <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else if (redirect) begin
            // Flush wins over everything; the word returning now is dropped.
            pc      <= redirect_pc & ~32'd3;
            pend    <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_pc <= pc;
                pc      <= pc + 32'd4;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
